// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster that shows a 256-pixel NES line buffer 2x2-scaled, issues per-line
// PPU render requests and the vblank pulse. Define SCANLINES_EN for half-intensity odd raster lines.
module vga_scanout #(
  parameter int H_OFS = 64,
  parameter int LINES = 240
) (
  input  logic       clock25,
  input  logic       reset,
  output logic [8:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       req,
  output logic [7:0] req_line,
  output logic       req_bank,
  output logic       vblank,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       hs,
  output logic       vs,
  output logic       de
);

  localparam logic [9:0] H_MAX      = 10'd799;
  localparam logic [9:0] V_MAX      = 10'd524;
  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] H_SYNC_S   = 10'd656;
  localparam logic [9:0] H_SYNC_E   = 10'd751;
  localparam logic [9:0] V_SYNC_S   = 10'd490;
  localparam logic [9:0] V_SYNC_E   = 10'd491;
  localparam logic [9:0] PIC_S      = 10'(H_OFS);
  localparam logic [9:0] PIC_E      = 10'(H_OFS + 512);
  localparam logic [9:0] V_REQ_LAST = 10'(2 * LINES - 4);
  localparam logic [9:0] V_VBLANK   = 10'(2 * LINES);

  function automatic logic [11:0] palette(input logic [5:0] idx);
    logic [11:0] c;
    c = 12'h000;
    case (idx)
      6'h00: c = 12'h666; 6'h01: c = 12'h02A; 6'h02: c = 12'h11B; 6'h03: c = 12'h40A;
      6'h04: c = 12'h607; 6'h05: c = 12'h703; 6'h06: c = 12'h710; 6'h07: c = 12'h520;
      6'h08: c = 12'h330; 6'h09: c = 12'h140; 6'h0A: c = 12'h050; 6'h0B: c = 12'h043;
      6'h0C: c = 12'h036;
      6'h10: c = 12'hAAA; 6'h11: c = 12'h15F; 6'h12: c = 12'h43F; 6'h13: c = 12'h81F;
      6'h14: c = 12'hB0D; 6'h15: c = 12'hC16; 6'h16: c = 12'hB31; 6'h17: c = 12'h950;
      6'h18: c = 12'h670; 6'h19: c = 12'h280; 6'h1A: c = 12'h0A0; 6'h1B: c = 12'h094;
      6'h1C: c = 12'h07B;
      6'h20: c = 12'hFFF; 6'h21: c = 12'h6AF; 6'h22: c = 12'h98F; 6'h23: c = 12'hD6F;
      6'h24: c = 12'hF5F; 6'h25: c = 12'hF6B; 6'h26: c = 12'hF85; 6'h27: c = 12'hEA3;
      6'h28: c = 12'hBC2; 6'h29: c = 12'h7D2; 6'h2A: c = 12'h4E5; 6'h2B: c = 12'h2DA;
      6'h2C: c = 12'h4CF; 6'h2D: c = 12'h444;
      6'h30: c = 12'hFFF; 6'h31: c = 12'hBDF; 6'h32: c = 12'hDCF; 6'h33: c = 12'hECF;
      6'h34: c = 12'hFBF; 6'h35: c = 12'hFBE; 6'h36: c = 12'hFCB; 6'h37: c = 12'hFDA;
      6'h38: c = 12'hEE9; 6'h39: c = 12'hCF9; 6'h3A: c = 12'hAFA; 6'h3B: c = 12'h9FD;
      6'h3C: c = 12'hAEF; 6'h3D: c = 12'hAAA;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        armed_q, armed_d;
  logic        req_q, req_d, req_bank_q, req_bank_d, vblank_q, vblank_d;
  logic [7:0]  req_line_q, req_line_d;
  logic [8:0]  addr_q, addr_d;
  logic        hs1_q, vs1_q, de1_q, pic1_q;
  logic        hs_q, vs_q, de_q;
  logic [11:0] rgb_q, rgb_d, pal;
  logic [9:0]  pic_off;
  logic        unused_bits;
`ifdef SCANLINES_EN
  logic        odd1_q;
`endif

  // Requests and vblank are decoded from the next beam position so they are high while h==0.
  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      h_d = '0;
      v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
    end
    armed_d    = armed_q;
    req_d      = 1'b0;
    req_line_d = req_line_q;
    req_bank_d = req_bank_q;
    vblank_d   = (h_d == '0) && (v_d == V_VBLANK);
    if (h_d == '0) begin
      if (v_d == V_MAX) begin
        req_d      = 1'b1;
        req_line_d = '0;
        req_bank_d = 1'b0;
        armed_d    = 1'b1;
      end else if (armed_q && !v_d[0] && (v_d <= V_REQ_LAST)) begin
        req_d      = 1'b1;
        req_line_d = v_d[8:1] + 8'd1;
        req_bank_d = ~v_d[1];
      end
    end
  end

  // Picture offset keeps 9 bits so px = offset[8:1] never carries into the bank bit.
  assign pic_off     = h_q - PIC_S;
  assign addr_d      = {v_q[1], pic_off[8:1]};
  assign unused_bits = ^{rd_data[7:6], pic_off[9], pic_off[0]};

  always_comb begin
    pal = palette(rd_data[5:0]);
`ifdef SCANLINES_EN
    if (odd1_q) pal = {1'b0, pal[11:9], 1'b0, pal[7:5], 1'b0, pal[3:1]};
`endif
    rgb_d = pic1_q ? pal : 12'h000;
  end

  // Line-request arming stays clear after reset until the v=524 prefetch; the first
  // frame after reset shows whatever the line buffer already holds.
  // NOTE: sequential state uses nonblocking assignments only.
  always_ff @(posedge clock25) begin
    if (reset) begin
      h_q        <= '0;
      v_q        <= '0;
      armed_q    <= 1'b0;
      req_q      <= 1'b0;
      req_line_q <= '0;
      req_bank_q <= 1'b0;
      vblank_q   <= 1'b0;
      addr_q     <= '0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      de1_q      <= 1'b0;
      pic1_q     <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      de_q       <= 1'b0;
      rgb_q      <= '0;
`ifdef SCANLINES_EN
      odd1_q     <= 1'b0;
`endif
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      armed_q    <= armed_d;
      req_q      <= req_d;
      req_line_q <= req_line_d;
      req_bank_q <= req_bank_d;
      vblank_q   <= vblank_d;
      addr_q     <= addr_d;
      hs1_q      <= !((h_q >= H_SYNC_S) && (h_q <= H_SYNC_E));
      vs1_q      <= !((v_q >= V_SYNC_S) && (v_q <= V_SYNC_E));
      de1_q      <= (h_q < H_VIS) && (v_q < V_VIS);
      pic1_q     <= (v_q < V_VIS) && (h_q >= PIC_S) && (h_q < PIC_E);
      hs_q       <= hs1_q;
      vs_q       <= vs1_q;
      de_q       <= de1_q;
      rgb_q      <= rgb_d;
`ifdef SCANLINES_EN
      odd1_q     <= v_q[0];
`endif
    end
  end

  assign rd_addr   = addr_q;
  assign req       = req_q;
  assign req_line  = req_line_q;
  assign req_bank  = req_bank_q;
  assign vblank    = vblank_q;
  assign {r, g, b} = rgb_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign de        = de_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: per-cycle video scoreboard, request/vblank model,
// table of pixel/address spot checks and hand sequences for sync widths and mid-frame reset.
module tb_vga_scanout;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } out_t;

  typedef struct {
    int          v;
    int          h;
    bit          chk_addr;
    logic [8:0]  addr;
    logic [11:0] rgb;
  } vec_t;

  localparam out_t RST_OUT = '{12'h000, 1'b1, 1'b1, 1'b0};

  localparam logic [11:0] PAL [64] = '{
    12'h666, 12'h02A, 12'h11B, 12'h40A, 12'h607, 12'h703, 12'h710, 12'h520,
    12'h330, 12'h140, 12'h050, 12'h043, 12'h036, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h15F, 12'h43F, 12'h81F, 12'hB0D, 12'hC16, 12'hB31, 12'h950,
    12'h670, 12'h280, 12'h0A0, 12'h094, 12'h07B, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h6AF, 12'h98F, 12'hD6F, 12'hF5F, 12'hF6B, 12'hF85, 12'hEA3,
    12'hBC2, 12'h7D2, 12'h4E5, 12'h2DA, 12'h4CF, 12'h444, 12'h000, 12'h000,
    12'hFFF, 12'hBDF, 12'hDCF, 12'hECF, 12'hFBF, 12'hFBE, 12'hFCB, 12'hFDA,
    12'hEE9, 12'hCF9, 12'hAFA, 12'h9FD, 12'hAEF, 12'hAAA, 12'h000, 12'h000
  };

  logic       clock25 = 1'b0;
  logic       reset   = 1'b1;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       req, req_bank, vblank, hs, vs, de;
  logic [7:0] req_line;
  logic [3:0] r, g, b;

  logic [7:0] mem [512];
  int         tb_h = 0, tb_v = 0, cyc = 0;
  int         vec_cnt = 0, miss_cnt = 0, req_seen = 0;
  out_t       sb_q [$];
  out_t       sb_e;
  bit         m_armed = 1'b0;
  logic [7:0] m_line = '0;
  logic       m_bank = 1'b0;
  logic       e_req, e_vb;
  vec_t       vecs [15];

  vga_scanout dut (
    .clock25 (clock25),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .req     (req),
    .req_line(req_line),
    .req_bank(req_bank),
    .vblank  (vblank),
    .r       (r),
    .g       (g),
    .b       (b),
    .hs      (hs),
    .vs      (vs),
    .de      (de)
  );

  always #20 clock25 = ~clock25;

  // Line memory: data for the registered address is available in the following cycle.
  assign rd_data = mem[rd_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (beam v=%0d h=%0d)", name, got, exp, tb_v, tb_h);
    end
  endtask

  task automatic timeout(input string name);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s: timed out (beam v=%0d h=%0d)", name, tb_v, tb_h);
  endtask

  function automatic logic [11:0] shade(input logic [11:0] c, input bit odd);
    logic [11:0] s;
    s = c;
`ifdef SCANLINES_EN
    if (odd) s = (c >> 1) & 12'h777;
`else
    if (odd) s = c;
`endif
    return s;
  endfunction

  function automatic out_t exp_at(input int h, input int v);
    out_t o;
    int   a;
    o.de  = (h < 640) && (v < 480);
    o.hs  = !((h >= 656) && (h <= 751));
    o.vs  = !((v == 490) || (v == 491));
    o.rgb = 12'h000;
    if ((v < 480) && (h >= 64) && (h < 576)) begin
      a     = ((v / 2) % 2) * 256 + (h - 64) / 2;
      o.rgb = shade(PAL[mem[a] & 8'h3F], (v % 2) == 1);
    end
    return o;
  endfunction

  task automatic wait_pos(input int v, input int h, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 85000; i++) begin
      if ((tb_v == v) && (tb_h == h)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock25);
    end
  endtask

  task automatic wait_for(input int sel, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (((sel == 0) ? hs : de) === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock25);
    end
  endtask

  // Independent beam-position model.
  always @(posedge clock25) begin
    cyc <= cyc + 1;
    if (reset) begin
      tb_h <= 0;
      tb_v <= 0;
    end else if (tb_h == 799) begin
      tb_h <= 0;
      tb_v <= (tb_v == 524) ? 0 : tb_v + 1;
    end else begin
      tb_h <= tb_h + 1;
    end
  end

  // Video scoreboard: expectation pushed for the current beam position, popped two cycles later.
  always @(negedge clock25) begin
    if (reset) begin
      sb_q.delete();
      sb_q.push_back(RST_OUT);
      sb_q.push_back(RST_OUT);
    end else begin
      sb_q.push_back(exp_at(tb_h, tb_v));
      if (sb_q.size() > 2) begin
        sb_e = sb_q.pop_front();
        check("video", {17'd0, r, g, b, hs, vs, de}, {17'd0, sb_e});
      end
    end
  end

  // Request / vblank model, compared every cycle.
  always @(negedge clock25) begin
    if (reset) begin
      m_armed = 1'b0;
      m_line  = '0;
      m_bank  = 1'b0;
    end else begin
      e_req = (tb_h == 0) && ((tb_v == 524) || (m_armed && (tb_v % 2 == 0) && (tb_v <= 476)));
      e_vb  = (tb_h == 0) && (tb_v == 480);
      if (e_req) begin
        m_line = (tb_v == 524) ? 8'd0 : 8'(tb_v / 2 + 1);
        m_bank = m_line[0];
        if (tb_v == 524) m_armed = 1'b1;
      end
      check("req", {31'd0, req}, {31'd0, e_req});
      check("vblank", {31'd0, vblank}, {31'd0, e_vb});
      check("req_line", {24'd0, req_line}, {24'd0, m_line});
      check("req_bank", {31'd0, req_bank}, {31'd0, m_bank});
      if (req === 1'b1) req_seen++;
    end
  end

  initial begin
    bit ok;
    int t0;

    // {beam v, pixel h, check addr, rd_addr expected for h+1, rgb expected for pixel h}
    vecs = '{
      '{0,   63, 1'b1, 9'h000, 12'h000},
      '{0,   64, 1'b1, 9'h000, 12'h666},
      '{0,   65, 1'b1, 9'h001, 12'h666},
      '{0,   66, 1'b1, 9'h001, 12'h02A},
      '{0,   94, 1'b1, 9'h00F, 12'h000},
      '{0,  108, 1'b1, 9'h016, 12'hB31},
      '{0,  574, 1'b1, 9'h0FF, 12'h000},
      '{0,  576, 1'b0, 9'h000, 12'h000},
      '{1,   66, 1'b1, 9'h001, 12'h02A},
      '{2,   64, 1'b1, 9'h100, 12'hFFF},
      '{2,  574, 1'b1, 9'h1FF, 12'hFFF},
      '{3,  300, 1'b1, 9'h176, 12'hFFF},
      '{4,   64, 1'b1, 9'h000, 12'h666},
      '{6,  320, 1'b1, 9'h180, 12'hFFF},
      '{50, 639, 1'b0, 9'h000, 12'h000}
    };
    for (int x = 0; x < 256; x++) begin
      mem[x]       = 8'(x & 8'h3F);
      mem[256 + x] = 8'h30;
    end

    repeat (4) @(posedge clock25);
    #1 reset = 1'b0;
    @(negedge clock25);
    check("rst_rgb", {20'd0, r, g, b}, 32'd0);
    check("rst_sync", {29'd0, hs, vs, de}, 32'd6);

    foreach (vecs[i]) begin
      wait_pos(vecs[i].v, vecs[i].h + 2, ok);
      if (!ok) timeout("table_wait");
      else begin
        if (vecs[i].chk_addr) check("tbl_addr", {23'd0, rd_addr}, {23'd0, vecs[i].addr});
        check("tbl_rgb", {20'd0, r, g, b}, {20'd0, shade(vecs[i].rgb, (vecs[i].v % 2) == 1)});
      end
    end

    wait_for(0, 1'b1, ok); if (!ok) timeout("hs_high");
    wait_for(0, 1'b0, ok); if (!ok) timeout("hs_fall");
    t0 = cyc;
    wait_for(0, 1'b1, ok); if (!ok) timeout("hs_rise");
    check("hs_low_width", cyc - t0, 96);
    wait_for(0, 1'b0, ok); if (!ok) timeout("hs_fall2");
    check("hs_period", cyc - t0, 800);

    wait_for(1, 1'b0, ok); if (!ok) timeout("de_low");
    wait_for(1, 1'b1, ok); if (!ok) timeout("de_rise");
    t0 = cyc;
    wait_for(1, 1'b0, ok); if (!ok) timeout("de_fall");
    check("de_width", cyc - t0, 640);

    // One-cycle reset in the middle of the frame at (v=100, h=300).
    wait_pos(100, 299, ok);
    if (!ok) timeout("reset_wait");
    @(posedge clock25);
    #1 reset = 1'b1;
    @(posedge clock25);
    #1 reset = 1'b0;
    @(negedge clock25);
    check("mid_rst_addr", {23'd0, rd_addr}, 32'd0);
    check("mid_rst_rgb", {20'd0, r, g, b}, 32'd0);
    check("mid_rst_sync", {29'd0, hs, vs, de}, 32'd6);
    check("mid_rst_req", {23'd0, req, req_line}, 32'd0);
    check("mid_rst_bank_vb", {30'd0, req_bank, vblank}, 32'd0);
    repeat (2) @(negedge clock25);
    check("restart_de", {31'd0, de}, 32'd1);
    wait_pos(0, 67, ok);
    if (!ok) timeout("restart_wait");
    else begin
      check("restart_addr", {23'd0, rd_addr}, 32'h001);
      check("restart_rgb", {20'd0, r, g, b}, 32'h666);
    end
    wait_pos(1, 10, ok);
    if (!ok) timeout("end_wait");
    check("req_before_prefetch", req_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
